// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_ctrl_pkg;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Active-low one-hot anode select, entry i lights digit i (digit 0 = cs).
  localparam logic [NUM_DIGITS-1:0][NUM_DIGITS-1:0] AN_ONEHOT = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  localparam logic [NUM_DIGITS-1:0] AN_RESET = 4'b1110;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// One decimal digit: counts 0..9 when enabled, carries out on 9->0.
module bcd_digit_counter
  import stopwatch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] val,
  output logic             carry
);

  logic [BCD_W-1:0] val_q, val_d;

  // Carry is combinational so the whole chain advances on the same edge.
  assign carry = en && (val_q == 4'd9);
  assign val   = val_q;

  // Next digit value: sync clear wins, else wrap at 9.
  always_comb begin
    val_d = val_q;
    if (clr)
      val_d = '0;
    else if (en)
      val_d = (val_q == 4'd9) ? '0 : val_q + 4'd1;
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause FSM, 4-digit BCD time, sticky wrap flag,
// and a free-running 7-segment digit scanner.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start_stop,
  input  logic                  clear,
  output logic [15:0]           digits,
  output logic                  running,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] an,
  output logic [BCD_W-1:0]      scan_bcd
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_e state_q, state_d;
  logic   running_q, running_d;
  logic   ovf_q, ovf_d;
  logic   count_en;

  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NUM_DIGITS-1:0][BCD_W-1:0] dig;
  logic [NUM_DIGITS:0]              dig_en;

  // Count only on ticks seen while already in RUN; clear suppresses counting.
  assign count_en  = (state_q == ST_RUN) && tick && !clear;
  assign dig_en[0] = count_en;

  // Ripple-enable chain: cs -> ds -> s1 -> s10; the top carry is the wrap.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_counter u_dig (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .en    (dig_en[i]),
      .val   (dig[i]),
      .carry (dig_en[i+1])
    );
  end

  // Next state, registered running decode and sticky overflow.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ST_IDLE;
      ovf_d   = 1'b0;
    end else begin
      if (dig_en[NUM_DIGITS])
        ovf_d = 1'b1;
      if (start_stop) begin
        unique case (state_q)
          ST_IDLE:  state_d = ST_RUN;
          ST_RUN:   state_d = ST_PAUSE;
          ST_PAUSE: state_d = ST_RUN;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
    running_d = (state_d == ST_RUN);
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

  // Scan divider: hold each digit SCAN_DIV cycles, then step the index.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Scan registers; independent of clear/start_stop/tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // an and scan_bcd both decode the same registered index.
  assign an       = AN_ONEHOT[idx_q];
  assign scan_bcd = dig[idx_q];
  assign digits   = dig;
  assign running  = running_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus, compared each
// cycle against a centisecond-integer model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0, start_stop = 1'b0, clear = 1'b0;
  logic [15:0] digits;
  logic        running, ovf;
  logic [3:0]  an, scan_bcd;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 run, 2 pause; time kept as plain centiseconds.
  int m_mode = 0;
  int m_cs   = 0;
  bit m_ovf  = 1'b0;
  int m_scan = 0;

  stopwatch_ctrl #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
    .clear(clear), .digits(digits), .running(running), .ovf(ovf),
    .an(an), .scan_bcd(scan_bcd)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cs = 0; m_ovf = 1'b0; m_scan = 0;
  endtask

  task automatic model_step(input bit ss, input bit cl, input bit tk);
    if (cl) begin
      m_mode = 0; m_cs = 0; m_ovf = 1'b0;
    end else begin
      if (m_mode == 1 && tk) begin
        m_cs = m_cs + 1;
        if (m_cs == 10000) begin m_cs = 0; m_ovf = 1'b1; end
      end
      if (ss) m_mode = (m_mode == 1) ? 2 : 1;
    end
    m_scan++;
  endtask

  task automatic check_all();
    logic [15:0] ed;
    int idx;
    logic [3:0] one;
    ed  = to_bcd(m_cs);
    idx = (m_scan / SD) % 4;
    one = 4'b0001 << idx;
    chk("digits",   digits, ed);
    chk("running",  {15'd0, running}, {15'd0, (m_mode == 1)});
    chk("ovf",      {15'd0, ovf}, {15'd0, m_ovf});
    chk("an",       {12'd0, an}, {12'd0, ~one});
    chk("scan_bcd", {12'd0, scan_bcd}, {12'd0, ed[idx*4 +: 4]});
  endtask

  // One clock: drive, take the edge, step the model, check #1 later.
  task automatic cyc(input bit ss, input bit cl, input bit tk);
    start_stop = ss; clear = cl; tick = tk;
    @(posedge clk);
    model_step(ss, cl, tk);
    #1;
    start_stop = 0; clear = 0; tick = 0;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1);
  endtask

  initial begin
    // Power-up reset
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_an", {12'd0, an}, 16'h000e);
    rst = 0;

    // Start, 7 ticks, stop -> 0007 paused; further ticks ignored
    cyc(1, 0, 0);
    ticks(7);
    cyc(1, 0, 0);
    chk("pause7_digits", digits, 16'h0007);
    chk("pause7_running", {15'd0, running}, 16'h0000);
    ticks(5);
    chk("pause7_hold", digits, 16'h0007);

    // Carry across digits: 0999 -> 1000
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    ticks(999);
    chk("at0999", digits, 16'h0999);
    cyc(0, 0, 1);
    chk("carry1000", digits, 16'h1000);

    // Wrap: 9999 -> 0000 with sticky ovf; counting continues
    ticks(8999);
    chk("at9999", digits, 16'h9999);
    chk("ovf_pre", {15'd0, ovf}, 16'h0000);
    cyc(0, 0, 1);
    chk("wrap_digits", digits, 16'h0000);
    chk("wrap_ovf", {15'd0, ovf}, 16'h0001);
    ticks(3);
    chk("wrap_cont", digits, 16'h0003);
    chk("ovf_sticky", {15'd0, ovf}, 16'h0001);

    // Clear beats simultaneous start_stop and tick
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    ticks(42);
    chk("at0042", digits, 16'h0042);
    cyc(1, 1, 1);
    chk("clr_prio_digits", digits, 16'h0000);
    chk("clr_prio_running", {15'd0, running}, 16'h0000);
    chk("clr_prio_ovf", {15'd0, ovf}, 16'h0000);

    // Tick leaving RUN counts; tick entering RUN does not
    cyc(1, 0, 0);
    ticks(5);
    cyc(1, 0, 1);
    chk("leave_run", digits, 16'h0006);
    chk("leave_run_running", {15'd0, running}, 16'h0000);
    cyc(1, 0, 1);
    chk("enter_run", digits, 16'h0006);
    chk("enter_run_running", {15'd0, running}, 16'h0001);

    // Scan pattern over a paused 1234
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    ticks(1234);
    cyc(1, 0, 0);
    chk("at1234", digits, 16'h1234);
    for (int i = 0; i < 4 * SD * 2; i++) cyc(0, 0, $urandom_range(0, 1));

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 1));

    // Async reset between edges while running at 0321
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    ticks(321);
    chk("at0321", digits, 16'h0321);
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 0;
    check_all();
    // After release the first digit is held a full SD cycles
    ticks(2 * SD + 1);
    chk("post_rst_digits", digits, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
